// File: rtl/truth_table_sequencer_if.sv
// ---------------------------------------------------------------------------
// truth_table_sequencer_if
// Bundles the sweep control and result signals of truth_table_sequencer.
// Signals are named from the sequencer's point of view:
//   i_start     request an 8-vector sweep
//   i_abort     terminate a sweep in progress
//   i_dut_x     output of the combinational circuit under control
//   o_abc       circuit input drive, {A,B,C}
//   o_busy      sweep in progress
//   o_done      one-cycle pulse at normal sweep completion
//   o_pass      last completed sweep matched the golden table
//   o_captured  sampled circuit output per vector
//   o_err_count number of mismatching vectors (0..8)
// master: the controlling side (and the circuit), slave: the sequencer.
// ---------------------------------------------------------------------------
interface truth_table_sequencer_if;
    logic       i_start;
    logic       i_abort;
    logic       i_dut_x;
    logic [2:0] o_abc;
    logic       o_busy;
    logic       o_done;
    logic       o_pass;
    logic [7:0] o_captured;
    logic [3:0] o_err_count;

    modport master (
        output i_start, i_abort, i_dut_x,
        input  o_abc, o_busy, o_done, o_pass, o_captured, o_err_count
    );

    modport slave (
        input  i_start, i_abort, i_dut_x,
        output o_abc, o_busy, o_done, o_pass, o_captured, o_err_count
    );
endinterface

// File: rtl/truth_table_sequencer.sv
// ---------------------------------------------------------------------------
// truth_table_sequencer
// Steps a 3-input combinational circuit through all 8 input vectors, holds
// each vector for SETTLE_CYCLES cycles, samples the circuit output and
// compares it against the golden table EXPECTED.
// Ports:
//   i_clk  clock, all state changes on the rising edge
//   i_rst  asynchronous active-high reset
//   bus    truth_table_sequencer_if.slave (start/abort/dut_x in, results out)
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ST_IDLE    | abc=000, waiting for start (abort has priority)
// ST_SETTLE  | abc=idx held while the circuit settles (SETTLE_CYCLES cycles)
// ST_SAMPLE  | one cycle; closing edge captures dut_x for vector idx
// ST_DONE    | one cycle done pulse, pass valid; returns to IDLE
// ---------------------------------------------------------------------------
module truth_table_sequencer #(
    parameter int         SETTLE_CYCLES = 2,
    parameter logic [7:0] EXPECTED      = 8'h90
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    truth_table_sequencer_if.slave bus
);

    // A setting of 0 behaves as 1; the counter is loaded with (cycles - 1)
    // and the state moves on at terminal count 0.
    localparam int         LP_SETTLE_EFF  = (SETTLE_CYCLES < 1) ? 1 : SETTLE_CYCLES;
    localparam logic [3:0] LP_SETTLE_LOAD = 4'(LP_SETTLE_EFF - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t     r_state;
    state_t     w_state_next;
    logic [2:0] r_idx;
    logic [3:0] r_settle_cnt;
    logic [7:0] r_captured;
    logic [3:0] r_err_count;
    logic       r_pass;

    logic       w_mismatch;
    logic [3:0] w_err_next;

    assign w_mismatch = (bus.i_dut_x != EXPECTED[r_idx]);
    // Saturate at 8 so the count can never wrap.
    assign w_err_next = (w_mismatch && (r_err_count != 4'd8)) ? (r_err_count + 4'd1)
                                                              : r_err_count;

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (bus.i_start && !bus.i_abort) begin
                    w_state_next = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (bus.i_abort) begin
                    w_state_next = ST_IDLE;
                end else if (r_settle_cnt == 4'd0) begin
                    w_state_next = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                if (bus.i_abort) begin
                    w_state_next = ST_IDLE;
                end else if (r_idx == 3'd7) begin
                    w_state_next = ST_DONE;
                end else begin
                    w_state_next = ST_SETTLE;
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Sweep datapath: vector index, settle timer and results
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_idx        <= 3'd0;
            r_settle_cnt <= 4'd0;
            r_captured   <= 8'h00;
            r_err_count  <= 4'd0;
            r_pass       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.i_start && !bus.i_abort) begin
                        r_idx        <= 3'd0;
                        r_settle_cnt <= LP_SETTLE_LOAD;
                        r_captured   <= 8'h00;
                        r_err_count  <= 4'd0;
                        r_pass       <= 1'b0;
                    end
                end
                ST_SETTLE: begin
                    if (bus.i_abort) begin
                        r_pass <= 1'b0;
                    end else if (r_settle_cnt != 4'd0) begin
                        r_settle_cnt <= r_settle_cnt - 4'd1;
                    end
                end
                ST_SAMPLE: begin
                    if (bus.i_abort) begin
                        r_pass <= 1'b0;
                    end else begin
                        r_captured[r_idx] <= bus.i_dut_x;
                        r_err_count       <= w_err_next;
                        if (r_idx != 3'd7) begin
                            r_idx        <= r_idx + 3'd1;
                            r_settle_cnt <= LP_SETTLE_LOAD;
                        end else begin
                            // Uses the count including vector 7 so pass is
                            // already valid while done is high.
                            r_pass <= (w_err_next == 4'd0);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs decoded from state
    always_comb begin
        bus.o_abc       = 3'b000;
        bus.o_busy      = 1'b0;
        bus.o_done      = 1'b0;
        bus.o_pass      = r_pass;
        bus.o_captured  = r_captured;
        bus.o_err_count = r_err_count;
        case (r_state)
            ST_SETTLE, ST_SAMPLE: begin
                bus.o_abc  = r_idx;
                bus.o_busy = 1'b1;
            end
            ST_DONE: begin
                bus.o_abc  = r_idx;
                bus.o_done = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_truth_table_sequencer.sv
module tb_truth_table_sequencer;

    typedef struct {
        logic [7:0] cap;
        logic [3:0] err;
        logic       pass;
    } exp_t;

    typedef struct {
        int         mode;   // 0 correct model, 1 stuck at 0, 2 inverted model
        logic [7:0] cap;
        logic [3:0] err;
        logic       pass;
    } vec_t;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    int   mode_a;
    int   a_run;
    int   a_done_cnt;
    int   b_run;
    int   b_gap;
    int   b_seen;
    int   b_done_cnt;
    exp_t sb[$];
    vec_t vecs[3];

    truth_table_sequencer_if ifa ();
    truth_table_sequencer_if ifb ();

    truth_table_sequencer #(.SETTLE_CYCLES(2), .EXPECTED(8'h90)) u_dut_a (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (ifa)
    );

    truth_table_sequencer #(.SETTLE_CYCLES(1), .EXPECTED(8'h90)) u_dut_b (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference circuit: X = NOR(A&(B^C), ~A)
    function automatic logic model_x(input logic [2:0] abc);
        return ~((abc[2] & (abc[1] ^ abc[0])) | ~abc[2]);
    endfunction

    always_comb begin
        case (mode_a)
            1:       ifa.i_dut_x = 1'b0;
            2:       ifa.i_dut_x = ~model_x(ifa.o_abc);
            default: ifa.i_dut_x = model_x(ifa.o_abc);
        endcase
    end

    always_comb ifb.i_dut_x = model_x(ifb.o_abc);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Instance A monitor: abc stepping, busy length, scoreboard at done
    always @(negedge clk) begin
        if (rst) begin
            a_run = 0;
        end else if (ifa.o_busy) begin
            chk("a_abc_step", 32'(ifa.o_abc), a_run / 3);
            a_run++;
        end else begin
            if (ifa.o_done) begin
                a_done_cnt++;
                chk("a_busy_len", a_run, 24);
                if (sb.size() == 0) begin
                    chk("a_sb_nonempty", 0, 1);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("a_captured", 32'(ifa.o_captured), 32'(e.cap));
                    chk("a_err_count", 32'(ifa.o_err_count), 32'(e.err));
                    chk("a_pass", 32'(ifa.o_pass), 32'(e.pass));
                end
            end else begin
                chk("a_idle_abc", 32'(ifa.o_abc), 0);
            end
            a_run = 0;
        end
    end

    // Instance B monitor: back-to-back sweep spacing
    always @(negedge clk) begin
        if (rst) begin
            b_run  = 0;
            b_gap  = 0;
            b_seen = 0;
        end else if (ifb.o_busy) begin
            if (b_run == 0 && b_seen != 0) chk("b_gap", b_gap, 2);
            chk("b_abc_step", 32'(ifb.o_abc), b_run / 2);
            b_run++;
        end else if (b_run != 0) begin
            chk("b_busy_len", b_run, 16);
            chk("b_done_after_busy", 32'(ifb.o_done), 1);
            chk("b_captured", 32'(ifb.o_captured), 32'h90);
            chk("b_pass", 32'(ifb.o_pass), 1);
            b_done_cnt++;
            b_seen = 1;
            b_run  = 0;
            b_gap  = 1;
        end else begin
            b_gap++;
        end
    end

    task automatic run_sweep(input int m, input logic [7:0] cap, input logic [3:0] err,
                             input logic pass, input bit abort_in_done);
        exp_t e;
        bit   got;
        mode_a = m;
        e.cap  = cap;
        e.err  = err;
        e.pass = pass;
        sb.push_back(e);
        ifa.i_start = 1'b1;
        tick();
        ifa.i_start = 1'b0;
        chk("start_busy", 32'(ifa.o_busy), 1);
        got = 1'b0;
        for (int c = 0; c < 100 && !got; c++) begin
            tick();
            if (ifa.o_done) got = 1'b1;
        end
        chk("sweep_done_seen", 32'(got), 1);
        if (abort_in_done) ifa.i_abort = 1'b1;
        tick();
        ifa.i_abort = 1'b0;
        chk("done_one_cycle", 32'(ifa.o_done), 0);
        repeat (3) tick();
        chk("hold_captured", 32'(ifa.o_captured), 32'(cap));
        chk("hold_err_count", 32'(ifa.o_err_count), 32'(err));
        chk("hold_pass", 32'(ifa.o_pass), 32'(pass));
    endtask

    initial begin
        bit found;
        int done_before;
        checks      = 0;
        failures    = 0;
        mode_a      = 0;
        a_done_cnt  = 0;
        b_done_cnt  = 0;
        rst         = 1'b1;
        ifa.i_start = 1'b0;
        ifa.i_abort = 1'b0;
        ifb.i_start = 1'b0;
        ifb.i_abort = 1'b0;

        vecs[0] = '{mode: 0, cap: 8'h90, err: 4'd0, pass: 1'b1};
        vecs[1] = '{mode: 1, cap: 8'h00, err: 4'd2, pass: 1'b0};
        vecs[2] = '{mode: 2, cap: 8'h6F, err: 4'd8, pass: 1'b0};

        #12;
        chk("rst_abc", 32'(ifa.o_abc), 0);
        chk("rst_busy", 32'(ifa.o_busy), 0);
        chk("rst_done", 32'(ifa.o_done), 0);
        chk("rst_pass", 32'(ifa.o_pass), 0);
        chk("rst_captured", 32'(ifa.o_captured), 0);
        chk("rst_err_count", 32'(ifa.o_err_count), 0);
        tick();
        rst = 1'b0;
        repeat (2) tick();

        foreach (vecs[i]) begin
            run_sweep(vecs[i].mode, vecs[i].cap, vecs[i].err, vecs[i].pass, 1'b0);
        end

        // Abort during SETTLE of vector 3
        mode_a      = 0;
        done_before = a_done_cnt;
        ifa.i_start = 1'b1;
        tick();
        ifa.i_start = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 50 && !found; c++) begin
            tick();
            if (ifa.o_busy && ifa.o_abc == 3'd3) found = 1'b1;
        end
        chk("abort_reach_v3", 32'(found), 1);
        ifa.i_abort = 1'b1;
        tick();
        ifa.i_abort = 1'b0;
        chk("abort_busy", 32'(ifa.o_busy), 0);
        chk("abort_abc", 32'(ifa.o_abc), 0);
        chk("abort_captured", 32'(ifa.o_captured), 0);
        chk("abort_err_count", 32'(ifa.o_err_count), 0);
        chk("abort_pass", 32'(ifa.o_pass), 0);
        repeat (30) tick();
        chk("abort_no_done", a_done_cnt, done_before);
        run_sweep(0, 8'h90, 4'd0, 1'b1, 1'b0);

        // Abort during DONE leaves the result standing
        run_sweep(0, 8'h90, 4'd0, 1'b1, 1'b1);

        // Abort wins over start in IDLE
        ifa.i_start = 1'b1;
        ifa.i_abort = 1'b1;
        tick();
        ifa.i_start = 1'b0;
        ifa.i_abort = 1'b0;
        chk("abort_start_idle", 32'(ifa.o_busy), 0);
        repeat (3) tick();
        chk("abort_start_idle_later", 32'(ifa.o_busy), 0);

        // Start held high on instance B
        ifb.i_start = 1'b1;
        repeat (60) tick();
        ifb.i_start = 1'b0;
        repeat (25) tick();
        chk("b_sweep_count", b_done_cnt, 4);

        // Reset mid-sweep with non-zero partial results
        mode_a      = 2;
        ifa.i_start = 1'b1;
        tick();
        ifa.i_start = 1'b0;
        repeat (10) @(posedge clk);
        #3;
        chk("pre_rst_err_nonzero", 32'(ifa.o_err_count != 4'd0), 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_abc", 32'(ifa.o_abc), 0);
        chk("mid_rst_busy", 32'(ifa.o_busy), 0);
        chk("mid_rst_done", 32'(ifa.o_done), 0);
        chk("mid_rst_pass", 32'(ifa.o_pass), 0);
        chk("mid_rst_captured", 32'(ifa.o_captured), 0);
        chk("mid_rst_err_count", 32'(ifa.o_err_count), 0);
        tick();
        rst = 1'b0;
        repeat (5) tick();
        chk("post_rst_idle", 32'(ifa.o_busy), 0);
        run_sweep(0, 8'h90, 4'd0, 1'b1, 1'b0);

        chk("sb_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/truth_table_sequencer.md
TRUTH_TABLE_SEQUENCER -- requirements
Module: truth_table_sequencer

Interface
REQ-001 The block SHALL have parameter SETTLE_CYCLES, default 2: clock cycles each input vector is held before sampling (legal 1..15; 0 SHALL behave as 1).
REQ-002 The block SHALL have parameter EXPECTED, default 8'h90: golden 3-input truth table; bit i is the expected output for input vector i = {A,B,C}.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  request a full 8-vector sweep; sampled in IDLE only.
REQ-006 abort  input  1  terminate a sweep in progress.
REQ-007 dut_x  input  1  output of the combinational circuit under control.
REQ-008 abc  output  3  drive to the circuit inputs; abc[2]=A, abc[1]=B, abc[0]=C.
REQ-009 busy  output  1  high while a sweep is in progress.
REQ-010 done  output  1  one-cycle pulse when a sweep completes normally.
REQ-011 pass  output  1  last completed sweep matched EXPECTED on all 8 vectors.
REQ-012 captured  output  8  sampled dut_x per vector; bit i = vector i.
REQ-013 err_count  output  4  number of mismatching vectors, range 0..8.

Function
REQ-014 The FSM SHALL have states IDLE, SETTLE, SAMPLE and DONE, with index register idx (3 bits) and settle counter (4 bits).
REQ-015 In IDLE, the block SHALL drive abc=3'b000 and busy=0.
REQ-016 IDLE with start=1 and abort=0 SHALL go to SETTLE on the next edge and SHALL set idx=0, abc=0, captured=0, err_count=0, pass=0 and busy=1.
REQ-017 The block SHALL stay in SETTLE for exactly SETTLE_CYCLES cycles with abc=idx held stable, then go to SAMPLE.
REQ-018 The SAMPLE state SHALL last 1 cycle; at its closing edge the block SHALL set captured[idx]<=dut_x, and SHALL increment err_count if dut_x != EXPECTED[idx].
REQ-019 From SAMPLE with idx<7, the block SHALL increment idx, update abc to the new idx on the same edge, and return to SETTLE.
REQ-020 From SAMPLE with idx=7, the block SHALL go to DONE.
REQ-021 Each vector SHALL occupy exactly SETTLE_CYCLES+1 cycles, so busy stays high for exactly 8*(SETTLE_CYCLES+1) cycles.
REQ-022 The DONE state SHALL last 1 cycle with done=1 and busy=0, and SHALL set pass=(err_count==0) using the final count including vector 7; the block then returns to IDLE.
REQ-023 pass, captured and err_count SHALL hold their values from DONE until the next accepted start or reset.
REQ-024 start SHALL be ignored in SETTLE, SAMPLE and DONE; a start held high continuously SHALL launch a new sweep only on the edge after DONE returns to IDLE.
REQ-025 abort=1 in SETTLE or SAMPLE SHALL force IDLE on the next edge, with no sample taken that edge, done never asserted, pass=0, and captured/err_count keeping their partial values.
REQ-026 abort and start both high in IDLE SHALL leave the block in IDLE; abort has priority.
REQ-027 abort=1 in DONE SHALL have no effect; the done pulse and pass value stand.
REQ-028 err_count SHALL never exceed 8 and SHALL never wrap.

Reset
REQ-029 rst=1 SHALL immediately, without waiting for a clock edge, force IDLE with abc=000, idx=0, busy=0, done=0, pass=0, captured=8'h00 and err_count=0.
REQ-030 rst asserted mid-sweep SHALL discard the sweep; after release the block SHALL wait in IDLE for start.

Verification
REQ-031 The bench SHALL cover these scenarios:
- rst pulse at arbitrary time, mid-sweep included -> all outputs at REQ-029 values before the next edge.
- SETTLE_CYCLES=2, dut_x driven by correct model X = NOR(A&(B^C), ~A), 1-cycle start -> abc steps 0..7 every 3 cycles, busy high for 24 cycles, one done pulse, captured=8'h90, err_count=0, pass=1.
- dut_x stuck at 0 -> captured=8'h00, err_count=2, pass=0.
- dut_x = inverse of correct model -> captured=8'h6F, err_count=8, pass=0.
- abort during SETTLE of vector 3 -> IDLE next cycle, abc=000, no done pulse, captured=8'h00, err_count=0 (correct model), pass=0; a subsequent start gives a full correct sweep.
- start held high for 60 cycles with SETTLE_CYCLES=1 -> back-to-back sweeps of 16 busy cycles each, separated by exactly one DONE cycle and one IDLE cycle.
